jt51_so_tx: RTL and testbench
=============================

# jt51_so_tx

Serial DAC transmitter for the FM output path. It takes the exact 16-bit signed left/right samples produced once per sample period by the channel accumulator and converts each to 10-bit mantissa / 3-bit exponent floating point. It shifts them out LSB-first on a single data line with per-channel sample-hold strobes for an external YM3012-style DAC. A one-deep pending buffer decouples sample production from transmission.

## Interface
- No parameters; word and frame sizes are fixed constants.
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-high reset.
- `cen` in 1 — clock enable; one serial bit per `cen` cycle.
- `load` in 1 — sample strobe; sampled only when `cen`=1.
- `left` in 16 — signed left sample, captured on an accepted `load`.
- `right` in 16 — signed right sample, captured on an accepted `load`.
- `clr_ovf` in 1 — clears `ovf`; sampled only when `cen`=1.
- `so` out 1 — serial data, registered.
- `sh1` out 1 — left-word hold strobe, registered.
- `sh2` out 1 — right-word hold strobe, registered.
- `busy` out 1 — frame in progress.
- `ovf` out 1 — sticky flag; set when a pending sample was overwritten.

## Operation
- Float conversion, per channel, at capture time. Exponent `e` is the smallest value in 1..7 such that `lin[15:e+8]` all equal `lin[15]`. Mantissa is `man = lin[e+8:e-1]`; if `e`=7, `man = lin[15:6]`. Reconstruction is `man` sign-extended, shifted left by `e-1`. Truncation only, no rounding.
- Word is 16 bits, sent LSB first: bits 0-2 = 0, bits 3-12 = `man[0..9]`, bits 13-15 = `e[0..2]`.
- Frame is 32 bits: left word, then right word.
- States:
  - IDLE: `so`=0, `busy`=0.
  - SHIFT_L: 16 bits, bit counter 0..15.
  - SHIFT_R: 16 bits, bit counter 0..15.
- Transitions, all on `cen`:
  - IDLE to SHIFT_L when a sample is available (accepted `load` or pending valid).
  - SHIFT_L to SHIFT_R after bit 15.
  - SHIFT_R to SHIFT_L after bit 15 if a sample is available, otherwise to IDLE.
- `sh1`=1 exactly while left bit 15 is on `so`. `sh2`=1 exactly while right bit 15 is on `so`. Otherwise both are 0.
- Load handling:
  - Idle, no pending: the sample goes straight to the shifter.
  - Busy: the sample goes to pending.
  - Pending already valid and not consumed this cycle: pending is overwritten by the new sample and `ovf` is set.
- Load on the last bit of SHIFT_R:
  - Pending empty: the new sample goes straight to the shifter.
  - Pending valid: pending goes to the shifter and the new sample goes to pending. No overflow.
- `ovf` clears on `clr_ovf`. A set event in the same `cen` cycle wins.

## Timing
- Reset values: `so`=0, `sh1`=0, `sh2`=0, `busy`=0, `ovf`=0, state=IDLE, pending empty.
- All state changes only on `clk` edges with `cen`=1. `load` and `clr_ovf` are ignored when `cen`=0.
- Latency: `load` accepted in IDLE at `cen` cycle N puts left bit 0 on `so` from cycle N+1. `busy` rises at N+1.
- Frame occupies exactly 32 `cen` cycles. Back-to-back frames have no gap.
- `busy` falls on the `cen` cycle after right bit 15 when nothing is pending.
- Reset mid-frame aborts immediately: outputs go to reset values and pending is discarded.

## Structure
- Shared package constants: `WORD_BITS`=16, `PAD_BITS`=3, `MAN_BITS`=10, `EXP_BITS`=3, and the state encoding IDLE/SHIFT_L/SHIFT_R.
- Conversion is one combinational sub-module, instantiated once per channel: existing `jt51_lin2exp` (ports `lin`, `man`, `exp`). Float words are formed before capture into the shift and pending registers.

## Test plan
- Idle load: `left`=16'h0123, `right`=16'hFFFF. Left word gives `man`=0x123, `e`=1; `so` reads 000,1100010010,100. Right word gives `man`=0x3FF, `e`=1. `sh1` pulses at cycle 16, `sh2` at cycle 32, `busy` low at cycle 33.
- Large values: `left`=16'h4000 gives `e`=7, `man`=0x100. `right`=16'h8000 gives `e`=7, `man`=0x200. Reconstructing both reproduces the input exactly.
- Back-to-back: `load` every 32 `cen` cycles, aligned with the frame's last bit. Continuous `so` stream, `busy` stays 1, `ovf`=0.
- Overflow: three loads A, B, C during one frame. B is overwritten, the next frame carries C, and `ovf`=1. `clr_ovf` then returns `ovf` to 0.
- `cen` gating: `cen` at 1/4 rate with `load` held high during a `cen`=0 cycle. That load is ignored, and bit timing advances only on `cen`.
- Reset at right bit 5: all outputs 0 next clock, and a fresh load after release starts a clean frame with left bit 0.

Source files
------------

// File: rtl/jt51_so_tx_pkg.sv
// Shared constants, state encoding and float word packing for the serial DAC transmitter.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package jt51_so_tx_pkg;

  localparam int WORD_BITS  = 16;
  localparam int PAD_BITS   = 3;
  localparam int MAN_BITS   = 10;
  localparam int EXP_BITS   = 3;
  localparam int FRAME_BITS = 2 * WORD_BITS;

  // FSM encoding kept as plain constants so older tools and scripts can match on it
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT_L = 2'd1;
  localparam logic [1:0] SHIFT_R = 2'd2;

  typedef logic [WORD_BITS-1:0]  word_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  // Serial word layout, LSB first on the wire: pad zeros, mantissa, exponent
  function automatic word_t make_word(input logic [MAN_BITS-1:0] man,
                                      input logic [EXP_BITS-1:0] e);
    return {e, man, {PAD_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/jt51_so_tx_if.sv
// Sample input / serial DAC output bundle of the transmitter.
// Latency: none (wires only).
// Backpressure: none; an unserviced pending sample is overwritten and flagged via ovf.
interface jt51_so_tx_if;

  logic        cen;
  logic        load;
  logic [15:0] left;
  logic [15:0] right;
  logic        clr_ovf;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic        busy;
  logic        ovf;

  modport master (
    output cen, load, left, right, clr_ovf,
    input  so, sh1, sh2, busy, ovf
  );

  modport slave (
    input  cen, load, left, right, clr_ovf,
    output so, sh1, sh2, busy, ovf
  );

endinterface

// File: rtl/jt51_lin2exp.sv
// Linear 16-bit signed sample to 10-bit mantissa / 3-bit exponent float (truncating).
// Latency: combinational.
// Backpressure: none.
module jt51_lin2exp
  import jt51_so_tx_pkg::*;
(
  input  logic [15:0]         lin,
  output logic [MAN_BITS-1:0] man,
  output logic [EXP_BITS-1:0] exp
);

  logic [15:0] mag;

  // Pick the smallest exponent whose dropped top bits are pure sign copies, then truncate
  always_comb begin
    mag = lin ^ {16{lin[15]}};
    exp = 3'd7;
    for (int k = 6; k >= 1; k--) begin
      if ((mag >> (k + 8)) == 16'd0) exp = 3'(k);
    end
    man = MAN_BITS'(lin >> (exp - 3'd1));
  end

endmodule

// File: rtl/jt51_so_tx.sv
// Float-converts L/R samples and shifts a 32-bit frame LSB-first with sh1/sh2 hold strobes.
// Latency: load accepted on cen cycle N puts left bit 0 on so at N+1; frame lasts 32 cen cycles.
// Backpressure: none; one-deep pending buffer, overwritten on a third load with ovf set.
module jt51_so_tx
  import jt51_so_tx_pkg::*;
(
  input logic         clk,
  input logic         rst,
  jt51_so_tx_if.slave bus
);

  logic [MAN_BITS-1:0] man_l, man_r;
  logic [EXP_BITS-1:0] exp_l, exp_r;

  jt51_lin2exp u_cvt_l (.lin(bus.left),  .man(man_l), .exp(exp_l));
  jt51_lin2exp u_cvt_r (.lin(bus.right), .man(man_r), .exp(exp_r));

  frame_t     new_frame;
  frame_t     frame;
  frame_t     pend;
  frame_t     start_frame;
  logic       pend_vld;
  logic [1:0] state;
  logic [3:0] cnt;
  logic       so_q, sh1_q, sh2_q, ovf_q;
  logic       load_acc, frame_end, start, set_ovf;
  logic [4:0] nxt_idx;

  assign new_frame   = {make_word(man_r, exp_r), make_word(man_l, exp_l)};
  assign load_acc    = bus.cen & bus.load;
  // A frame may begin from idle or seamlessly on the last right bit
  assign frame_end   = (state == IDLE) || ((state == SHIFT_R) && (cnt == 4'd15));
  assign start       = bus.cen && frame_end && (load_acc || pend_vld);
  // The older pending sample always leaves first
  assign start_frame = pend_vld ? pend : new_frame;
  // Frame index of the bit that will be on so after this cen cycle
  assign nxt_idx     = {(state == SHIFT_R), cnt} + 5'd1;
  // Loading while something is already waiting (and not leaving now) loses that sample
  assign set_ovf     = load_acc && pend_vld && !frame_end;

  // Shifter FSM: so/sh1/sh2 always reflect the bit currently presented to the DAC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      frame <= '0;
      so_q  <= 1'b0;
      sh1_q <= 1'b0;
      sh2_q <= 1'b0;
    end else if (bus.cen) begin
      if (start) begin
        state <= SHIFT_L;
        cnt   <= 4'd0;
        frame <= start_frame;
        so_q  <= start_frame[0];
        sh1_q <= 1'b0;
        sh2_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            so_q  <= 1'b0;
            sh1_q <= 1'b0;
            sh2_q <= 1'b0;
          end
          SHIFT_L: begin
            so_q  <= frame[nxt_idx];
            cnt   <= cnt + 4'd1;
            sh1_q <= (cnt == 4'd14);
            sh2_q <= 1'b0;
            if (cnt == 4'd15) state <= SHIFT_R;
          end
          SHIFT_R: begin
            sh1_q <= 1'b0;
            if (cnt == 4'd15) begin
              state <= IDLE;
              cnt   <= 4'd0;
              so_q  <= 1'b0;
              sh2_q <= 1'b0;
            end else begin
              so_q  <= frame[nxt_idx];
              cnt   <= cnt + 4'd1;
              sh2_q <= (cnt == 4'd14);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
            so_q  <= 1'b0;
            sh1_q <= 1'b0;
            sh2_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // One-deep pending buffer: filled by loads that cannot start a frame, drained at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (bus.cen) begin
      if (start) begin
        if (pend_vld) begin
          if (load_acc) pend <= new_frame;
          else          pend_vld <= 1'b0;
        end
      end else if (load_acc) begin
        pend     <= new_frame;
        pend_vld <= 1'b1;
      end
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       ovf_q <= 1'b0;
    else if (set_ovf)              ovf_q <= 1'b1;
    else if (bus.cen && bus.clr_ovf) ovf_q <= 1'b0;
  end

  assign bus.so   = so_q;
  assign bus.sh1  = sh1_q;
  assign bus.sh2  = sh2_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_jt51_so_tx.sv
// Directed bench for jt51_so_tx: hand-computed float words, strobes, overflow, cen gating, reset.
// Latency: samples outputs 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_jt51_so_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jt51_so_tx_if bus ();

  jt51_so_tx dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] cap_so, cap_sh1, cap_sh2, cap_ovf;
  int          busy_low;
  int          ovf_high;
  int          stable_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [15:0] l, input logic [15:0] r);
    bus.load  = 1'b1;
    bus.left  = l;
    bus.right = r;
    cyc();
    bus.load  = 1'b0;
  endtask

  // Capture n consecutive cen=1 cycles; optional loads presented during samples a1/a2
  task automatic run(input int n,
                     input int a1, input logic [15:0] l1, input logic [15:0] r1,
                     input int a2, input logic [15:0] l2, input logic [15:0] r2);
    cap_so   = '0;
    cap_sh1  = '0;
    cap_sh2  = '0;
    cap_ovf  = '0;
    busy_low = 0;
    ovf_high = 0;
    for (int i = 0; i < n; i++) begin
      cap_so[i]  = bus.so;
      cap_sh1[i] = bus.sh1;
      cap_sh2[i] = bus.sh2;
      cap_ovf[i] = bus.ovf;
      if (!bus.busy) busy_low++;
      if (bus.ovf)   ovf_high++;
      bus.load = 1'b0;
      if (i == a1) begin bus.load = 1'b1; bus.left = l1; bus.right = r1; end
      if (i == a2) begin bus.load = 1'b1; bus.left = l2; bus.right = r2; end
      cyc();
    end
    bus.load = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [15:0] lw, input logic [15:0] rw);
    check({tag, "_lword"}, {16'h0, cap_so[base +: 16]}, {16'h0, lw});
    check({tag, "_rword"}, {16'h0, cap_so[base + 16 +: 16]}, {16'h0, rw});
    check({tag, "_sh1"}, cap_sh1[base +: 32], 32'h0000_8000);
    check({tag, "_sh2"}, cap_sh2[base +: 32], 32'h8000_0000);
  endtask

  function automatic logic [31:0] recon(input logic [15:0] w);
    logic signed [31:0] m;
    m = {{22{w[12]}}, w[12:3]};
    return 32'(m <<< (w[15:13] - 3'd1));
  endfunction

  initial begin
    bus.cen     = 1'b1;
    bus.load    = 1'b0;
    bus.left    = 16'h0;
    bus.right   = 16'h0;
    bus.clr_ovf = 1'b0;
    stable_err  = 0;

    // Reset state
    repeat (3) cyc();
    check("rst_so",   {31'h0, bus.so},   32'h0);
    check("rst_sh1",  {31'h0, bus.sh1},  32'h0);
    check("rst_sh2",  {31'h0, bus.sh2},  32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_ovf",  {31'h0, bus.ovf},  32'h0);
    rst = 1'b0;
    cyc();

    // Idle load: 0x0123 -> man 0x123 e 1, 0xFFFF -> man 0x3FF e 1
    start_load(16'h0123, 16'hFFFF);
    run(32, -1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
    check_frame("idle", 0, 16'h2918, 16'h3FF8);
    check("idle_man_l", {22'h0, cap_so[12:3]},  32'h123);
    check("idle_exp_l", {29'h0, cap_so[15:13]}, 32'h1);
    check("idle_pad_l", {29'h0, cap_so[2:0]},   32'h0);
    check("idle_busy_low", 32'(busy_low), 32'h0);
    check("idle_busy_end", {31'h0, bus.busy}, 32'h0);
    check("idle_so_end",   {31'h0, bus.so},   32'h0);

    // Large values use the top exponent and reconstruct exactly
    start_load(16'h4000, 16'h8000);
    run(32, -1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
    check_frame("large", 0, 16'hE800, 16'hF000);
    check("large_recon_l", recon(cap_so[15:0]),  32'h0000_4000);
    check("large_recon_r", recon(cap_so[31:16]), 32'hFFFF_8000);

    // Back-to-back: loads aligned with the last right bit, no gap
    start_load(16'h0001, 16'hFFFE);
    run(96, 31, 16'h0200, 16'hFE00, 63, 16'h7FFF, 16'h0000);
    check_frame("b2b0", 0,  16'h2008, 16'h3FF0);
    check_frame("b2b1", 32, 16'h4800, 16'h3000);
    check_frame("b2b2", 64, 16'hEFF8, 16'h2000);
    check("b2b_busy_low", 32'(busy_low), 32'h0);
    check("b2b_ovf_high", 32'(ovf_high), 32'h0);
    check("b2b_busy_end", {31'h0, bus.busy}, 32'h0);

    // Overflow: A starts, B pends, C overwrites B
    start_load(16'h0123, 16'hFFFF);
    run(64, 5, 16'h4000, 16'h8000, 10, 16'h0200, 16'hFE00);
    check("ovf_after_b", {31'h0, cap_ovf[6]},  32'h0);
    check("ovf_after_c", {31'h0, cap_ovf[11]}, 32'h1);
    check_frame("ovf0", 0,  16'h2918, 16'h3FF8);
    check_frame("ovf1", 32, 16'h4800, 16'h3000);
    check("ovf_busy_low", 32'(busy_low), 32'h0);
    check("ovf_busy_end", {31'h0, bus.busy}, 32'h0);
    check("ovf_sticky",   {31'h0, bus.ovf},  32'h1);
    bus.clr_ovf = 1'b1;
    cyc();
    bus.clr_ovf = 1'b0;
    check("ovf_cleared",  {31'h0, bus.ovf},  32'h0);

    // Load on last bit with pending valid: pending goes out, new sample waits, no overflow
    start_load(16'h0001, 16'hFFFE);
    run(96, 5, 16'h0200, 16'hFE00, 31, 16'h7FFF, 16'h0000);
    check_frame("lastp0", 0,  16'h2008, 16'h3FF0);
    check_frame("lastp1", 32, 16'h4800, 16'h3000);
    check_frame("lastp2", 64, 16'hEFF8, 16'h2000);
    check("lastp_ovf_high", 32'(ovf_high), 32'h0);
    check("lastp_busy_end", {31'h0, bus.busy}, 32'h0);

    // cen gating: load during cen=0 ignored, bits advance only on cen
    bus.cen   = 1'b0;
    bus.load  = 1'b1;
    bus.left  = 16'h0123;
    bus.right = 16'h0000;
    cyc();
    bus.load  = 1'b0;
    repeat (2) cyc();
    check("cen_ignored_busy", {31'h0, bus.busy}, 32'h0);
    bus.cen = 1'b1;
    start_load(16'h0001, 16'h0200);
    cap_so  = '0;
    cap_sh1 = '0;
    cap_sh2 = '0;
    for (int i = 0; i < 32; i++) begin
      cap_so[i]  = bus.so;
      cap_sh1[i] = bus.sh1;
      cap_sh2[i] = bus.sh2;
      for (int j = 0; j < 3; j++) begin
        bus.cen = 1'b0;
        cyc();
        if (bus.so !== cap_so[i] || bus.sh1 !== cap_sh1[i] ||
            bus.sh2 !== cap_sh2[i] || bus.busy !== 1'b1) stable_err++;
      end
      bus.cen = 1'b1;
      cyc();
    end
    check_frame("cen", 0, 16'h2008, 16'h4800);
    check("cen_stable", 32'(stable_err), 32'h0);
    check("cen_busy_end", {31'h0, bus.busy}, 32'h0);

    // Reset at right bit 5 with a pending sample and ovf set
    start_load(16'h7FFF, 16'hFE00);
    run(21, 3, 16'h0001, 16'hFFFE, 5, 16'h0200, 16'hFE00);
    check("pre_rst_ovf",  {31'h0, bus.ovf},  32'h1);
    check("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    cyc();
    check("mid_rst_so",   {31'h0, bus.so},   32'h0);
    check("mid_rst_sh1",  {31'h0, bus.sh1},  32'h0);
    check("mid_rst_sh2",  {31'h0, bus.sh2},  32'h0);
    check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("mid_rst_ovf",  {31'h0, bus.ovf},  32'h0);
    rst = 1'b0;
    cyc();
    check("post_rst_idle", {31'h0, bus.busy}, 32'h0);
    start_load(16'h0123, 16'h0000);
    run(32, -1, 16'h0, 16'h0, -1, 16'h0, 16'h0);
    check_frame("post_rst", 0, 16'h2918, 16'h2000);
    check("post_rst_busy_end", {31'h0, bus.busy}, 32'h0);
    check("post_rst_so_end",   {31'h0, bus.so},   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
